alu_driver: RTL and testbench
=============================

ALU_DRIVER -- requirements
Module: alu_driver

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width.
REQ-002 Parameter OP_WAIT, default 2, cycles to wait for single-pass ops (sel 0-6); legal range >= 1.
REQ-003 Parameter MOD_WAIT, default 256, cycles to wait for the iterative mod op (sel 7); legal range >= 1.
REQ-004 clk  in  1  single clock, all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 cmd_valid  in  1  command offered; cmd_ready  out  1  driver can accept.
REQ-007 cmd_sel  in  3  op code; cmd_a, cmd_b  in  WIDTH  operands.
REQ-008 alu_sel  out  3; alu_a, alu_b  out  WIDTH  operands driven to the ALU.
REQ-009 alu_reset  out  1  start pulse for the ALU mod FSM; alu_result  in  WIDTH  ALU output.
REQ-010 rsp_valid  out  1; rsp_ready  in  1; rsp_result  out  WIDTH; rsp_sel  out  3  echo of the op code.

Function
REQ-011 FSM states SHALL be IDLE, MODRST, WAIT, RESP.
REQ-012 IDLE: cmd_ready=1; on cmd_valid, latch cmd_sel/a/b into alu_sel/a/b and rsp_sel; go to MODRST if sel==7, else to WAIT with counter=OP_WAIT-1.
REQ-013 MODRST: alu_reset=1 for exactly one cycle, then go to WAIT with counter=MOD_WAIT-1.
REQ-014 WAIT: if counter==0, register alu_result into rsp_result and go to RESP; else decrement counter.
REQ-015 RESP: rsp_valid=1; on rsp_ready go to IDLE; rsp_result/rsp_sel held stable while rsp_valid=1 and rsp_ready=0.
REQ-016 cmd_ready SHALL be 0 in every state except IDLE; cmd_valid outside IDLE ignored, no command lost or duplicated.
REQ-017 alu_sel/a/b SHALL stay constant from acceptance to the next acceptance, including through IDLE.
REQ-018 Latency: rsp_valid first high OP_WAIT+1 cycles after accepting edge for sel 0-6; MOD_WAIT+2 for sel 7.
REQ-019 alu_reset SHALL be 0 in all states except MODRST.
REQ-020 Counter width SHALL be clog2 of max(OP_WAIT, MOD_WAIT)+1; no wrap-around.
REQ-021 Throughput: max one command per (latency+1) cycles; response handshake and new acceptance never in the same cycle.

Reset
REQ-022 While reset=1 at an edge: state=IDLE, counter=0, all registered outputs (alu_sel, alu_a, alu_b, alu_reset, rsp_valid, rsp_result, rsp_sel) = 0.
REQ-023 cmd_ready SHALL be 0 while reset=1, 1 in the first cycle after reset deasserts.
REQ-024 Reset in any state SHALL abort the command in flight with no response produced.

Structure
REQ-025 Shared package alu_pkg SHALL hold op-code constants (AND=0, OR=1, XOR=2, NOR=3, SLT=4, ADD=5, SUB=6, MOD=7), FSM state type, default WIDTH.
REQ-026 One sub-module, alu_wait_timer (loadable down-counter with zero flag), SHALL implement the WAIT counter.
REQ-027 The ALU is not instantiated inside alu_driver; bench connects both.

Verification (driver + alu, OP_WAIT=2, MOD_WAIT=256)
REQ-028 Reset, then a=10 b=3 sel=5 -> rsp_result=13, rsp_sel=5, rsp_valid 3 cycles after accept, alu_reset never 1.
REQ-029 a=10 b=3 sel=7 -> alu_reset=1 exactly the cycle after accept, rsp_result=1 at 258 cycles.
REQ-030 a=10 b=3 sel=6, rsp_ready=0 for 10 cycles -> rsp_valid and rsp_result=7 held, cmd_ready=0, concurrent cmd_valid ignored; single response after rsp_ready=1.
REQ-031 Reset asserted mid-WAIT of sel=7 -> alu_reset=0, rsp_valid=0, cmd_ready=1 the cycle after release; next a=10 b=3 sel=0 -> 2.
REQ-032 Back-to-back sel 0..7, a=10 b=3, rsp_ready=1 -> results 2, 11, 9, 0xFFFFFFF4, 0, 13, 7, 1 in order.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op codes, FSM state type and sizing helper for the ALU command driver.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_NOR = 3'd3;
  localparam logic [2:0] OP_SLT = 3'd4;
  localparam logic [2:0] OP_ADD = 3'd5;
  localparam logic [2:0] OP_SUB = 3'd6;
  localparam logic [2:0] OP_MOD = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MODRST,
    ST_WAIT,
    ST_RESP
  } drv_state_t;

  // Wide enough to hold the larger wait value without wrapping.
  function automatic int unsigned wait_cnt_width(input int unsigned op_wait,
                                                 input int unsigned mod_wait);
    int unsigned m;
    m = (op_wait > mod_wait) ? op_wait : mod_wait;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/alu_driver_if.sv
// Command, ALU-side and response signals of the driver grouped into one bundle.
interface alu_driver_if #(
  parameter int unsigned WIDTH = alu_pkg::ALU_WIDTH
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_sel;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;

  logic [2:0]       alu_sel;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_reset;
  logic [WIDTH-1:0] alu_result;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [2:0]       rsp_sel;

  modport slave (
    input  cmd_valid, cmd_sel, cmd_a, cmd_b, alu_result, rsp_ready,
    output cmd_ready, alu_sel, alu_a, alu_b, alu_reset,
           rsp_valid, rsp_result, rsp_sel
  );

  modport master (
    output cmd_valid, cmd_sel, cmd_a, cmd_b, alu_result, rsp_ready,
    input  cmd_ready, alu_sel, alu_a, alu_b, alu_reset,
           rsp_valid, rsp_result, rsp_sel
  );

endinterface

// File: rtl/alu_wait_timer.sv
// Loadable down-counter that saturates at zero and flags when it gets there.
module alu_wait_timer #(
  parameter int unsigned CW = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_dec,
  output logic          o_zero
);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/alu_driver.sv
// Sequences one command at a time into an external ALU, waits a fixed number
// of cycles for the result and returns it over a valid/ready response port.
module alu_driver
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH    = ALU_WIDTH,
  parameter int unsigned OP_WAIT  = 2,
  parameter int unsigned MOD_WAIT = 256
) (
  input logic         clk,
  input logic         reset,
  alu_driver_if.slave bus
);

  localparam int unsigned   CW       = wait_cnt_width(OP_WAIT, MOD_WAIT);
  localparam logic [CW-1:0] OP_LOAD  = CW'(OP_WAIT - 1);
  localparam logic [CW-1:0] MOD_LOAD = CW'(MOD_WAIT - 1);

  drv_state_t       r_state;
  drv_state_t       w_next;
  logic             w_accept;
  logic             w_load;
  logic [CW-1:0]    w_load_val;
  logic             w_dec;
  logic             w_zero;

  logic [2:0]       r_alu_sel;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic             r_alu_reset;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_result;
  logic [2:0]       r_rsp_sel;

  alu_wait_timer #(
    .CW(CW)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_load_val(w_load_val),
    .i_dec     (w_dec),
    .o_zero    (w_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_load     = 1'b0;
    w_load_val = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          w_accept = 1'b1;
          if (bus.cmd_sel == OP_MOD) begin
            w_next = ST_MODRST;
          end else begin
            w_next     = ST_WAIT;
            w_load     = 1'b1;
            w_load_val = OP_LOAD;
          end
        end
      end
      ST_MODRST: begin
        w_next     = ST_WAIT;
        w_load     = 1'b1;
        w_load_val = MOD_LOAD;
      end
      ST_WAIT: begin
        if (w_zero) begin
          w_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_dec = (r_state == ST_WAIT) && !w_zero;

  // Strobes are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_alu_sel    <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_reset  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_sel    <= '0;
    end else begin
      if (w_accept) begin
        r_alu_sel <= bus.cmd_sel;
        r_alu_a   <= bus.cmd_a;
        r_alu_b   <= bus.cmd_b;
        r_rsp_sel <= bus.cmd_sel;
      end
      if ((r_state == ST_WAIT) && w_zero) begin
        r_rsp_result <= bus.alu_result;
      end
      r_alu_reset <= (w_next == ST_MODRST);
      r_rsp_valid <= (w_next == ST_RESP);
    end
  end

  assign bus.cmd_ready  = (r_state == ST_IDLE) && !reset;
  assign bus.alu_sel    = r_alu_sel;
  assign bus.alu_a      = r_alu_a;
  assign bus.alu_b      = r_alu_b;
  assign bus.alu_reset  = r_alu_reset;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_sel    = r_rsp_sel;

endmodule

// File: tb/tb_alu_driver.sv
// Directed bench for alu_driver paired with a small behavioural ALU.
module tb_alu_driver;
  import alu_pkg::*;

  localparam int unsigned LAT_LIMIT = 400;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  alu_driver_if #(.WIDTH(32)) bus ();

  alu_driver #(
    .WIDTH   (32),
    .OP_WAIT (2),
    .MOD_WAIT(256)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: single-pass ops combinational, mod by repeated subtraction.
  logic [31:0] r_mod;
  logic [31:0] w_res;

  always @(posedge clk) begin
    if (bus.alu_reset) begin
      r_mod <= bus.alu_a;
    end else if ((bus.alu_b != 0) && (r_mod >= bus.alu_b)) begin
      r_mod <= r_mod - bus.alu_b;
    end
  end

  always_comb begin
    w_res = '0;
    case (bus.alu_sel)
      OP_AND:  w_res = bus.alu_a & bus.alu_b;
      OP_OR:   w_res = bus.alu_a | bus.alu_b;
      OP_XOR:  w_res = bus.alu_a ^ bus.alu_b;
      OP_NOR:  w_res = ~(bus.alu_a | bus.alu_b);
      OP_SLT:  w_res = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 32'd1 : 32'd0;
      OP_ADD:  w_res = bus.alu_a + bus.alu_b;
      OP_SUB:  w_res = bus.alu_a - bus.alu_b;
      default: w_res = r_mod;
    endcase
  end

  assign bus.alu_result = w_res;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a command and returns just after its accepting edge.
  task automatic send_cmd(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
    int unsigned n;
    bus.cmd_valid = 1'b1;
    bus.cmd_sel   = sel;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    n = 0;
    while (!bus.cmd_ready && n < LAT_LIMIT) begin
      tick();
      n++;
    end
    chk("accept_ready", 32'(bus.cmd_ready), 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // Cycle 1 is the cycle right after the accepting edge.
  task automatic wait_rsp(output int unsigned lat, output int unsigned rst_hits,
                          output int unsigned rst_cycle);
    int unsigned n;
    n         = 1;
    rst_hits  = 0;
    rst_cycle = 0;
    forever begin
      if (bus.alu_reset) begin
        rst_hits++;
        rst_cycle = n;
      end
      if (bus.rsp_valid || n >= LAT_LIMIT) break;
      tick();
      n++;
    end
    lat = n;
  endtask

  task automatic run_cmd(input string tag, input logic [2:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input int unsigned exp_lat, input int unsigned exp_rst);
    int unsigned lat, hits, rcyc;
    send_cmd(sel, a, b);
    chk({tag, "_alu_sel"}, 32'(bus.alu_sel), 32'(sel));
    wait_rsp(lat, hits, rcyc);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_result"}, bus.rsp_result, exp_res);
    chk({tag, "_rsp_sel"}, 32'(bus.rsp_sel), 32'(sel));
    chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
    chk({tag, "_rst_hits"}, hits, (exp_rst != 0) ? 32'd1 : 32'd0);
    chk({tag, "_rst_cycle"}, rcyc, exp_rst);
    tick();
    chk({tag, "_rsp_drop"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_idle_ready"}, 32'(bus.cmd_ready), 32'd1);
  endtask

  logic [2:0]  seq_sel [8];
  logic [31:0] seq_res [8];

  initial begin
    int unsigned lat, hits, rcyc;
    n_cmp         = 0;
    n_err         = 0;
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_sel   = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.rsp_ready = 1'b1;

    repeat (3) tick();
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_alu_reset", 32'(bus.alu_reset), 32'd0);
    chk("rst_alu_sel", 32'(bus.alu_sel), 32'd0);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_alu_b", bus.alu_b, 32'd0);
    chk("rst_rsp_result", bus.rsp_result, 32'd0);
    chk("rst_rsp_sel", 32'(bus.rsp_sel), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 32'(bus.cmd_ready), 32'd1);

    run_cmd("add", OP_ADD, 32'd10, 32'd3, 32'd13, 3, 0);
    tick();
    chk("hold_alu_a", bus.alu_a, 32'd10);
    chk("hold_alu_b", bus.alu_b, 32'd3);

    run_cmd("mod", OP_MOD, 32'd10, 32'd3, 32'd1, 258, 1);

    // Response stalled: output must hold and a competing command be ignored.
    bus.rsp_ready = 1'b0;
    send_cmd(OP_SUB, 32'd10, 32'd3);
    wait_rsp(lat, hits, rcyc);
    chk("stall_lat", lat, 32'd3);
    bus.cmd_valid = 1'b1;
    bus.cmd_sel   = OP_AND;
    bus.cmd_a     = 32'd5;
    bus.cmd_b     = 32'd5;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_valid", 32'(bus.rsp_valid), 32'd1);
      chk("stall_result", bus.rsp_result, 32'd7);
      chk("stall_rsp_sel", 32'(bus.rsp_sel), 32'(OP_SUB));
      chk("stall_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      chk("stall_alu_sel", 32'(bus.alu_sel), 32'(OP_SUB));
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    chk("stall_release", 32'(bus.rsp_valid), 32'd0);
    tick();
    chk("stall_no_dup", 32'(bus.rsp_valid), 32'd0);
    chk("stall_not_taken", bus.alu_a, 32'd10);

    // Abort a mod op mid-wait.
    send_cmd(OP_MOD, 32'd10, 32'd3);
    repeat (50) tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    chk("abort_ready", 32'(bus.cmd_ready), 32'd1);
    chk("abort_valid", 32'(bus.rsp_valid), 32'd0);
    chk("abort_alu_reset", 32'(bus.alu_reset), 32'd0);
    repeat (5) tick();
    chk("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
    run_cmd("post_abort_and", OP_AND, 32'd10, 32'd3, 32'd2, 3, 0);

    seq_sel = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_ADD, OP_SUB, OP_MOD};
    seq_res = '{32'd2, 32'd11, 32'd9, 32'hFFFF_FFF4, 32'd0, 32'd13, 32'd7, 32'd1};
    for (int unsigned k = 0; k < 8; k++) begin
      run_cmd($sformatf("seq%0d", k), seq_sel[k], 32'd10, 32'd3, seq_res[k],
              (seq_sel[k] == OP_MOD) ? 258 : 3, (seq_sel[k] == OP_MOD) ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
